eth_depacker: RTL and testbench

ETH_DEPACKER -- requirements
Module: eth_depacker

---
 rtl/eth_pkg.sv | 48 ++++
 rtl/eth_depacker_crc32.sv | 40 ++++
 rtl/eth_depacker.sv | 220 ++++++++++++++++++++++
 tb/tb_eth_depacker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types, frame geometry and CRC-32 helper for the RMII depacker.
package eth_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DEST     = 3'd2,
    S_SRC      = 3'd3,
    S_LEN      = 3'd4,
    S_DATA     = 3'd5,
    S_FCS      = 3'd6,
    S_DRAIN    = 3'd7
  } eth_state_t;

  localparam int unsigned ADDR_DIBITS = 24;
  localparam int unsigned LEN_DIBITS  = 8;
  localparam int unsigned DATA_DIBITS = 1280;
  localparam int unsigned FCS_DIBITS  = 16;

  localparam logic [12:0] ADDR_LAST = 13'(ADDR_DIBITS - 1);
  localparam logic [12:0] LEN_LAST  = 13'(LEN_DIBITS - 1);
  localparam logic [12:0] DATA_LAST = 13'(DATA_DIBITS - 1);
  localparam logic [12:0] FCS_LAST  = 13'(FCS_DIBITS - 1);

  localparam logic [4:0] MIN_PREAMBLE_DIBITS = 5'd8;
  localparam logic [4:0] PRE_CNT_MAX         = 5'd31;
  localparam logic [1:0] PRE_DIBIT           = 2'b01;
  localparam logic [1:0] SFD_DIBIT           = 2'b11;
  localparam logic [1:0] BCAST_DIBIT         = 2'b11;

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // MSB-first CRC-32 update; dibit bit 0 is the earlier bit on the wire.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[31] ^ dibit[i]) begin
        c = {c[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_depacker_crc32.sv
// Dibit-serial CRC-32 engine; axiod is the complemented register, bit-mirrored FCS order.
module crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [31:0] axiod
);

  logic [31:0] crc_q, crc_d;
  logic        vld_q;

  // Next CRC value when a dibit is presented.
  always_comb begin
    crc_d = crc_q;
    if (axiiv) begin
      crc_d = crc32_dibit(crc_q, axiid);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q <= CRC_INIT;
      vld_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      vld_q <= axiiv;
    end
  end

  assign axiov = vld_q;
  assign axiod = ~crc_q;

endmodule

// File: rtl/eth_depacker.sv
// RMII receive depacker: strips preamble/SFD, captures length, streams payload, checks FCS.
// Broadcast-only destination filter is compiled in when ETH_DEPACKER_ADDR_FILTER_EN is defined.
module eth_depacker
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_crsdv,
  input  logic [1:0]  phy_rxd,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic [15:0] len_field,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        frame_err
);

  eth_state_t  state_q, state_d;
  logic [12:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]  pre_q, pre_d;
  logic [15:0] len_q, len_d;
  logic [31:0] fcs_q, fcs_d;
  logic [31:0] crc_lat_q, crc_lat_d;
  logic        axiov_q, axiov_d;
  logic [1:0]  axiod_q, axiod_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        crc_feed, crc_rst, crc_vld;
  logic [31:0] crc_val;
  logic [4:0]  fcs_idx;
`ifdef ETH_DEPACKER_ADDR_FILTER_EN
  logic        addr_bad_q, addr_bad_d;
`endif

  // Engine is held at its initial value for as long as the receiver sits in Idle.
  assign crc_rst = rst & (state_q != S_IDLE);

  crc32 u_crc (
    .clk   (clk),
    .rst   (crc_rst),
    .axiiv (crc_feed),
    .axiid (phy_rxd),
    .axiov (crc_vld),
    .axiod (crc_val)
  );

  // First wire bit of FCS dibit i lands at bit 31-2i.
  assign fcs_idx = 5'd31 - {cnt_q[3:0], 1'b0};

  // Next-state and output decode for the frame walker.
  always_comb begin
    state_d   = state_q;
    cnt_inc   = cnt_q;
    pre_d     = pre_q;
    len_d     = len_q;
    fcs_d     = fcs_q;
    crc_lat_d = crc_lat_q;
    axiov_d   = 1'b0;
    axiod_d   = axiod_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    err_d     = 1'b0;
    crc_feed  = 1'b0;
`ifdef ETH_DEPACKER_ADDR_FILTER_EN
    addr_bad_d = addr_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (phy_crsdv && (phy_rxd == PRE_DIBIT)) begin
          state_d = S_PREAMBLE;
          pre_d   = 5'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREAMBLE: begin
        if (!phy_crsdv) begin
          state_d = S_IDLE;
        end else if (phy_rxd == PRE_DIBIT) begin
          pre_d = (pre_q == PRE_CNT_MAX) ? pre_q : pre_q + 5'd1;
        end else if ((phy_rxd == SFD_DIBIT) && (pre_q >= MIN_PREAMBLE_DIBITS)) begin
          state_d = S_DEST;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DEST: begin
        if (!phy_crsdv) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          crc_feed = 1'b1;
          cnt_inc  = cnt_q + 13'd1;
`ifdef ETH_DEPACKER_ADDR_FILTER_EN
          addr_bad_d = ((cnt_q == 13'd0) ? 1'b0 : addr_bad_q) | (phy_rxd != BCAST_DIBIT);
          if (cnt_q == ADDR_LAST) begin
            if (addr_bad_d) begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end else begin
              state_d = S_SRC;
            end
          end else begin
            state_d = S_DEST;
          end
`else
          state_d = (cnt_q == ADDR_LAST) ? S_SRC : S_DEST;
`endif
        end
      end
      S_SRC: begin
        if (!phy_crsdv) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          crc_feed = 1'b1;
          cnt_inc  = cnt_q + 13'd1;
          state_d  = (cnt_q == ADDR_LAST) ? S_LEN : S_SRC;
        end
      end
      S_LEN: begin
        if (!phy_crsdv) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          crc_feed = 1'b1;
          cnt_inc  = cnt_q + 13'd1;
          len_d[{cnt_q[2:0], 1'b0} +: 2] = phy_rxd;
          state_d  = (cnt_q == LEN_LAST) ? S_DATA : S_LEN;
        end
      end
      S_DATA: begin
        if (!phy_crsdv) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          crc_feed = 1'b1;
          axiov_d  = 1'b1;
          axiod_d  = phy_rxd;
          cnt_inc  = cnt_q + 13'd1;
          state_d  = (cnt_q == DATA_LAST) ? S_FCS : S_DATA;
        end
      end
      S_FCS: begin
        // The engine's output settles one cycle after the last data dibit.
        if (crc_vld && (cnt_q == 13'd0)) begin
          crc_lat_d = crc_val;
        end else begin
          crc_lat_d = crc_lat_q;
        end
        if (!phy_crsdv) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          fcs_d[fcs_idx]        = phy_rxd[0];
          fcs_d[fcs_idx - 5'd1] = phy_rxd[1];
          cnt_inc = cnt_q + 13'd1;
          if (cnt_q == FCS_LAST) begin
            done_d  = 1'b1;
            ok_d    = ({fcs_q[31:2], phy_rxd[0], phy_rxd[1]} == crc_lat_q);
            state_d = S_DRAIN;
          end else begin
            state_d = S_FCS;
          end
        end
      end
      S_DRAIN: begin
        state_d = phy_crsdv ? S_DRAIN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cnt_d = (state_d != state_q) ? 13'd0 : cnt_inc;
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 13'd0;
      pre_q     <= 5'd0;
      len_q     <= 16'd0;
      fcs_q     <= 32'd0;
      crc_lat_q <= 32'd0;
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
`ifdef ETH_DEPACKER_ADDR_FILTER_EN
      addr_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      len_q     <= len_d;
      fcs_q     <= fcs_d;
      crc_lat_q <= crc_lat_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
`ifdef ETH_DEPACKER_ADDR_FILTER_EN
      addr_bad_q <= addr_bad_d;
`endif
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign len_field  = len_q;
  assign frame_done = done_q;
  assign crc_ok     = ok_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_eth_depacker.sv
// Self-checking bench for eth_depacker: byte-level Ethernet frame model plus per-cycle compare.
module tb_eth_depacker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        phy_crsdv = 1'b0;
  logic [1:0]  phy_rxd = 2'b00;
  logic        axiov;
  logic [1:0]  axiod;
  logic [15:0] len_field;
  logic        frame_done, crc_ok, frame_err;

  eth_depacker dut (
    .clk        (clk),
    .rst        (rst),
    .phy_crsdv  (phy_crsdv),
    .phy_rxd    (phy_rxd),
    .axiov      (axiov),
    .axiod      (axiod),
    .len_field  (len_field),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_axv = 0, n_done = 0, n_err = 0;
  logic        chk_en = 1'b0;
  logic        exp_v = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_ok = 1'b0, exp_rst = 1'b0;
  logic [1:0]  exp_d = 2'b00;
  logic [15:0] exp_len = 16'd0;
  logic [1:0]  body[$];
  logic [1:0]  len_tab [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Outputs expected after a posedge are set at the preceding negedge.
  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      chk("axiov", 32'(axiov), 32'(exp_v));
      if (exp_v || exp_rst) chk("axiod", 32'(axiod), 32'(exp_d));
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      chk("frame_err", 32'(frame_err), 32'(exp_err));
      chk("crc_ok", 32'(crc_ok), 32'(exp_ok));
      chk("len_field", 32'(len_field), 32'(exp_len));
      if (axiov === 1'b1) n_axv++;
      if (frame_done === 1'b1) n_done++;
      if (frame_err === 1'b1) n_err++;
    end
  end

  // Standard reflected Ethernet CRC-32, one byte at a time.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // FCS over the first nd dibits of body, dibits packed LSB-first into bytes.
  function automatic logic [31:0] fcs_of(input int nd);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nd / 4; i++)
      c = crc_step(c, {body[4*i+3], body[4*i+2], body[4*i+1], body[4*i]});
    return ~c;
  endfunction

  function automatic logic model_ok();
    logic [31:0] rx;
    rx = 32'd0;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++) rx[8*b+2*j +: 2] = body[1336 + 4*b + j];
    return rx == fcs_of(1336);
  endfunction

  // Dest(24) Src(24) Len(8) Data(1280 ramp) Fcs(16), FCS bytes little-endian.
  task automatic build(input logic alt_dest);
    logic [31:0] f;
    body.delete();
    for (int i = 0; i < 24; i++) body.push_back(2'b11);
    if (alt_dest) body[3] = 2'b10;
    for (int i = 0; i < 24; i++) body.push_back(2'b10);
    for (int i = 0; i < 8; i++) body.push_back(len_tab[i]);
    for (int i = 0; i < 1280; i++) body.push_back(i[1:0]);
    f = fcs_of(1336);
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++) body.push_back(f[8*b+2*j +: 2]);
  endtask

  task automatic send(input int pre_n, input int cut_at, input int rst_at);
    logic acc, ok_m, bad;
    acc  = (pre_n >= 8);
    ok_m = model_ok();
    bad  = 1'b0;
`ifdef ETH_DEPACKER_ADDR_FILTER_EN
    for (int i = 0; i < 24; i++) if (body[i] != 2'b11) bad = 1'b1;
`endif
    for (int i = 0; i <= pre_n; i++) begin
      @(negedge clk);
      rst = 1'b1; phy_crsdv = 1'b1; phy_rxd = (i == pre_n) ? 2'b11 : 2'b01;
      exp_v = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_rst = 1'b0;
    end
    for (int k = 0; k < 1352; k++) begin
      @(negedge clk);
      exp_v = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_rst = 1'b0;
      if (k == rst_at) begin
        rst = 1'b0; exp_rst = 1'b1; exp_d = 2'b00; exp_ok = 1'b0; exp_len = 16'd0;
        break;
      end
      if (k == cut_at) begin
        phy_crsdv = 1'b0; exp_err = acc;
        break;
      end
      phy_rxd = body[k];
      if (acc) begin
        if (k == 23 && bad) begin
          exp_err = 1'b1; acc = 1'b0;
        end else if (k >= 48 && k < 56) begin
          exp_len[2*(k-48) +: 2] = body[k];
        end else if (k >= 56 && k < 1336) begin
          exp_v = 1'b1; exp_d = body[k];
        end else if (k == 1351) begin
          exp_done = 1'b1; exp_ok = ok_m;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b1; phy_crsdv = 1'b0;
      exp_v = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_rst = 1'b0;
    end
  endtask

  initial begin
    int a0, d0, e0;
    logic [31:0] c;
    string s;
    len_tab = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01};

    @(negedge clk); rst = 1'b0; exp_rst = 1'b1; exp_d = 2'b00; chk_en = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; exp_rst = 1'b0;

    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < s.len(); i++) c = crc_step(c, s[i]);
    chk("crc_model_check_value", ~c, 32'hCBF43926);

    // Good frame, 31-dibit preamble
    build(1'b0);
    chk("model_ok_good", 32'(model_ok()), 32'd1);
    a0 = n_axv; d0 = n_done; e0 = n_err;
    send(31, -1, -1);
    chk("good_axiov_count", 32'(n_axv - a0), 32'd1280);
    chk("good_done_count", 32'(n_done - d0), 32'd1);
    chk("good_err_count", 32'(n_err - e0), 32'd0);
    chk("good_len_literal", 32'(len_field), 32'h73EA);
    chk("good_crc_ok_literal", 32'(crc_ok), 32'd1);

    // One payload dibit corrupted
    body[256] = body[256] ^ 2'b01;
    chk("model_ok_flip", 32'(model_ok()), 32'd0);
    a0 = n_axv; d0 = n_done;
    send(31, -1, -1);
    chk("flip_axiov_count", 32'(n_axv - a0), 32'd1280);
    chk("flip_done_count", 32'(n_done - d0), 32'd1);
    chk("flip_crc_ok_literal", 32'(crc_ok), 32'd0);

    // Carrier lost at data dibit 500, then minimum-preamble good frame
    build(1'b0);
    a0 = n_axv; d0 = n_done; e0 = n_err;
    send(31, 56 + 500, -1);
    chk("drop_axiov_count", 32'(n_axv - a0), 32'd500);
    chk("drop_err_count", 32'(n_err - e0), 32'd1);
    chk("drop_done_count", 32'(n_done - d0), 32'd0);
    d0 = n_done;
    send(8, -1, -1);
    chk("pre8_done_count", 32'(n_done - d0), 32'd1);
    chk("pre8_crc_ok_literal", 32'(crc_ok), 32'd1);

    // Short preambles are rejected silently
    a0 = n_axv; d0 = n_done; e0 = n_err;
    send(7, -1, -1);
    send(5, -1, -1);
    chk("short_pre_axiov_count", 32'(n_axv - a0), 32'd0);
    chk("short_pre_done_count", 32'(n_done - d0), 32'd0);
    chk("short_pre_err_count", 32'(n_err - e0), 32'd0);

    // Carrier lost during preamble: no error
    e0 = n_err;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      phy_crsdv = (i < 4); phy_rxd = 2'b01;
      exp_v = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_rst = 1'b0;
    end
    chk("pre_drop_err_count", 32'(n_err - e0), 32'd0);

    // Non-broadcast destination dibit 3
    build(1'b1);
    a0 = n_axv; d0 = n_done; e0 = n_err;
    send(31, -1, -1);
`ifdef ETH_DEPACKER_ADDR_FILTER_EN
    chk("filt_axiov_count", 32'(n_axv - a0), 32'd0);
    chk("filt_err_count", 32'(n_err - e0), 32'd1);
    chk("filt_done_count", 32'(n_done - d0), 32'd0);
`else
    chk("nofilt_axiov_count", 32'(n_axv - a0), 32'd1280);
    chk("nofilt_done_count", 32'(n_done - d0), 32'd1);
    chk("nofilt_crc_ok_literal", 32'(crc_ok), 32'd1);
`endif

    // Reset at data dibit 100, then recovery
    build(1'b0);
    a0 = n_axv; d0 = n_done; e0 = n_err;
    send(31, -1, 56 + 100);
    chk("rst_axiov_count", 32'(n_axv - a0), 32'd100);
    chk("rst_done_count", 32'(n_done - d0), 32'd0);
    chk("rst_err_count", 32'(n_err - e0), 32'd0);
    chk("rst_len_literal", 32'(len_field), 32'd0);
    d0 = n_done;
    send(31, -1, -1);
    chk("recover_done_count", 32'(n_done - d0), 32'd1);
    chk("recover_crc_ok_literal", 32'(crc_ok), 32'd1);

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
